mem_bus_bridge: RTL
===================

// Module: mem_bus_bridge
// PURPOSE
//  Bridges the CPU's internal memory bus (address, read/write strobe and transfer-bus data) to an
//  external asynchronous SRAM/ROM port. It sits downstream of the CPU top level, in place of the
//  zero-latency test memory. It sequences chip-enable, output-enable and write-enable with
//  programmable wait states, latches read data, and pulses ready so control can stall.
// PARAMETERS
//  WAIT_STATES  2        ACCESS-phase length in clk cycles; legal 1..15, 0 is treated as 1
//  ROM_BASE     16'hF000 writes to addr >= ROM_BASE are suppressed (ROM region)
// PORTS
//  clk         in   1   system clock (the divided CPU clock)
//  rst_n       in   1   asynchronous, active-low reset
//  cpu_req     in   1   level request; sampled only in IDLE
//  cpu_rw      in   1   1 = read, 0 = write
//  cpu_addr    in   16  {high byte, low byte} memory address
//  cpu_wdata   in   8   write data
//  cpu_rdata   out  8   latched read data
//  cpu_ready   out  1   one-cycle completion pulse
//  cpu_busy    out  1   high in every non-IDLE state
//  mem_addr_h  out  8   external address, high byte
//  mem_addr_l  out  8   external address, low byte
//  mem_wdata   out  8   external write data
//  mem_doe     out  1   drive enable for the external data tristate
//  mem_rdata   in   8   external read data
//  mem_ce_n    out  1   chip enable, active low
//  mem_oe_n    out  1   output enable, active low
//  mem_we_n    out  1   write enable, active low
// BEHAVIOUR
//  - Reset (async, immediate, including mid-transaction):
//    - state = IDLE.
//    - mem_ce_n, mem_oe_n, mem_we_n = 1; mem_doe = 0.
//    - cpu_ready, cpu_busy = 0.
//    - cpu_rdata, mem_addr_h/l, mem_wdata = 0.
//  - FSM: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE. Moore outputs only, decoded from registered state; no glitches.
//  - IDLE: when cpu_req = 1 at a clk edge, capture cpu_addr, cpu_wdata, cpu_rw and the ROM hit
//    (addr >= ROM_BASE), then go to SETUP.
//  - Captured values are held for the whole transaction; CPU-side input changes after capture are ignored.
//  - SETUP (1 cycle):
//    - mem_ce_n = 0; address valid.
//    - write: mem_doe = 1.
//    - oe_n and we_n stay high.
//  - ACCESS (W cycles; counter loads W-1 and decrements; leave at 0):
//    - mem_ce_n = 0.
//    - read: mem_oe_n = 0.
//    - write to a non-ROM address: mem_we_n = 0, mem_doe = 1.
//    - write to a ROM address: mem_we_n stays 1 and mem_doe = 0; the timing is otherwise identical.
//  - Read data: mem_rdata is registered into cpu_rdata at the edge that ends the last ACCESS cycle.
//    cpu_rdata holds until the next read completes; writes never change it.
//  - HOLD (1 cycle):
//    - mem_ce_n = 0; mem_oe_n and mem_we_n = 1.
//    - write: mem_doe stays 1, giving data hold after the we_n rising edge.
//    - cpu_ready = 1.
//  - Latency: cpu_ready is high in the (W+2)th cycle after the accepting edge. One transaction
//    takes W+3 cycles including the IDLE cycle.
//  - Back-to-back: if cpu_req is still 1 in the following IDLE, a new transaction is accepted.
//    The requester drops cpu_req in its cpu_ready cycle to get exactly one access.
//  - cpu_req during non-IDLE states is ignored; it is not queued.
//  - Counter width is 4 bits; WAIT_STATES > 15 is a configuration error.
// TESTING
//  1. W=2, read 0x1234 with mem_rdata=0xA5:
//     {mem_addr_h,mem_addr_l}=0x1234 from SETUP; oe_n low exactly 2 cycles;
//     ready pulses 4 cycles after accept; cpu_rdata=0xA5.
//  2. W=2, write 0x0200 <- 0x3C:
//     we_n low exactly 2 cycles; mem_doe high 4 cycles (SETUP..HOLD); mem_wdata=0x3C; cpu_rdata unchanged.
//  3. Write 0xFFFC <- 0x55 (ROM): we_n never low, mem_doe never high; ready still pulses at cycle 4.
//  4. cpu_req held high for reads: one ready every 5 cycles; ce_n high exactly one cycle (IDLE) between accesses.
//  5. Change cpu_addr to 0xBEEF during ACCESS: mem address stays 0x1234 until the next accept.
//  6. rst_n low in the 2nd ACCESS cycle of a write:
//     we_n, ce_n go high and mem_doe low with no clk edge; busy=0.
//     After release, a req starts from SETUP.

Source files
------------

// File: rtl/mem_bus_bridge_if.sv
// CPU memory bus plus external async SRAM/ROM pins, bundled for the bridge.
// Latency: none (wires only).
// Backpressure: none here; the bridge stalls the CPU through cpu_ready/cpu_busy.
// Ports (via modports):
//   master - CPU/requester side and external memory model (drives cpu_* requests, mem_rdata)
//   slave  - the bridge (drives cpu_rdata/ready/busy and all mem_* strobes/address/data)
interface mem_bus_bridge_if;
    logic        cpu_req;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_busy;
    logic [7:0]  mem_addr_h;
    logic [7:0]  mem_addr_l;
    logic [7:0]  mem_wdata;
    logic        mem_doe;
    logic [7:0]  mem_rdata;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  mem_addr_h, mem_addr_l, mem_wdata, mem_doe,
        input  mem_ce_n, mem_oe_n, mem_we_n
    );

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, cpu_busy,
        output mem_addr_h, mem_addr_l, mem_wdata, mem_doe,
        output mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// Sequences CE/OE/WE for an external async SRAM/ROM from the CPU memory bus.
// Latency: cpu_ready pulses WAIT_STATES+2 cycles after the accepting edge.
// Backpressure: cpu_req is sampled only in IDLE; requests while busy are dropped.
// Ports: clk, rst_n (async active-low), bus (mem_bus_bridge_if.slave).
module mem_bus_bridge #(
    parameter int          WAIT_STATES = 2,        // ACCESS length, 1..15 (0 behaves as 1)
    parameter logic [15:0] ROM_BASE    = 16'hF000  // writes at or above this are suppressed
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_bridge_if.slave    bus
);

    localparam int         W_EFF    = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
    // 4-bit counter: WAIT_STATES above 15 is not a supported configuration.
    localparam logic [3:0] CNT_LOAD = 4'(W_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic        rom_q, rom_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;

    // Pin-level strobes are registered from the next state so they are
    // glitch-free and drop immediately on async reset.
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        doe_q, doe_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        wr_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        rom_d   = rom_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    rw_d    = bus.cpu_rw;
                    rom_d   = (bus.cpu_addr >= ROM_BASE);
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Sample the device on the edge that closes the OE window.
                    if (rw_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ROM-region writes run the same timing with WE and data drive masked.
        wr_en   = !rw_d && !rom_d;
        ce_n_d  = (state_d == ST_IDLE);
        oe_n_d  = !((state_d == ST_ACCESS) && rw_d);
        we_n_d  = !((state_d == ST_ACCESS) && wr_en);
        // Data drive spans SETUP..HOLD so data is stable around both WE edges.
        doe_d   = (state_d != ST_IDLE) && wr_en;
        ready_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b1;
            rom_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            rom_q   <= rom_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            doe_q   <= doe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_ready  = ready_q;
    assign bus.cpu_busy   = busy_q;
    assign bus.mem_addr_h = addr_q[15:8];
    assign bus.mem_addr_l = addr_q[7:0];
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_doe    = doe_q;
    assign bus.mem_ce_n   = ce_n_q;
    assign bus.mem_oe_n   = oe_n_q;
    assign bus.mem_we_n   = we_n_q;

endmodule
